// File: rtl/sound_square_ctrl.sv
// sound_square_ctrl: NRx0-NRx4 register front end and frame sequencer for one square channel (optional readback: SQ_CTRL_READBACK_EN)
module sound_square_ctrl #(
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter bit         HAS_SWEEP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sound_en,
  input  logic        div_tick,
  input  logic        cs,
  input  logic [7:0]  a,
  input  logic [7:0]  din,
  input  logic        wr,
  input  logic        rd,
  output logic [7:0]  dout,
  output logic [2:0]  sweep_time,
  output logic        sweep_decreasing,
  output logic [2:0]  num_sweep_shifts,
  output logic [1:0]  wave_duty,
  output logic [5:0]  length,
  output logic [3:0]  initial_volume,
  output logic        envelope_increasing,
  output logic [2:0]  num_envelope_sweeps,
  output logic [10:0] frequency,
  output logic        single,
  output logic        start,
  output logic        clk_length_ctr,
  output logic        clk_sweep,
  output logic        clk_vol_env,
  output logic        dac_on
);
  logic [7:0] off;
  logic       hit;
  logic       we;
  logic [6:0] nr0;
  logic [7:0] nr1, nr2, nr3;
  logic       nr4_single;
  logic [2:0] nr4_freq_hi;
  logic [2:0] step;
  logic [2:0] step_nxt;
  assign off      = a - BASE_ADDR;
  assign hit      = cs && off < 8'd5;
  assign we       = hit && wr && sound_en;
  assign step_nxt = step + 3'd1;
  assign sweep_time          = HAS_SWEEP ? nr0[6:4] : 3'd0;
  assign sweep_decreasing    = HAS_SWEEP ? nr0[3] : 1'b0;
  assign num_sweep_shifts    = HAS_SWEEP ? nr0[2:0] : 3'd0;
  assign wave_duty           = nr1[7:6];
  assign length              = nr1[5:0];
  assign initial_volume      = nr2[7:4];
  assign envelope_increasing = nr2[3];
  assign num_envelope_sweeps = nr2[2:0];
  assign frequency           = {nr4_freq_hi, nr3};
  assign single              = nr4_single;
  assign dac_on              = |nr2[7:3];
  // register writes, trigger pulse and frame sequencer; clocks change only when step changes
  always_ff @(posedge clk or posedge rst)
    if (rst || !sound_en) begin
      nr0            <= '0;
      nr1            <= '0;
      nr2            <= '0;
      nr3            <= '0;
      nr4_single     <= 1'b0;
      nr4_freq_hi    <= '0;
      start          <= 1'b0;
      step           <= '0;
      clk_length_ctr <= 1'b0;
      clk_sweep      <= 1'b0;
      clk_vol_env    <= 1'b0;
    end else begin
      if (we && off == 8'd0 && HAS_SWEEP) nr0 <= din[6:0];
      if (we && off == 8'd1) nr1 <= din;
      if (we && off == 8'd2) nr2 <= din;
      if (we && off == 8'd3) nr3 <= din;
      if (we && off == 8'd4) begin
        nr4_single  <= din[6];
        nr4_freq_hi <= din[2:0];
      end
      start <= we && off == 8'd4 && din[7] && dac_on;
      if (div_tick) begin
        step           <= step_nxt;
        clk_length_ctr <= ~step_nxt[0];
        clk_sweep      <= step_nxt[1];
        clk_vol_env    <= &step_nxt;
      end
    end
`ifdef SQ_CTRL_READBACK_EN
  logic [7:0] rdata;
  // masked read value of the addressed register
  always_comb
    rdata = off == 8'd0 ? (HAS_SWEEP ? {1'b1, nr0} : 8'hFF) :
            off == 8'd1 ? (nr1 | 8'h3F) :
            off == 8'd2 ? nr2 :
            off == 8'd3 ? 8'hFF :
            {1'b1, nr4_single, 6'h3F};
  // registered read data, idle value 8'hFF
  always_ff @(posedge clk or posedge rst)
    if (rst) dout <= 8'hFF;
    else dout <= (hit && rd) ? rdata : 8'hFF;
`else
  logic unused_rd;
  assign unused_rd = rd;
  assign dout      = 8'hFF;
`endif
endmodule

// File: tb/tb_sound_square_ctrl.sv
// tb_sound_square_ctrl: directed self-checking bench for sound_square_ctrl
module tb_sound_square_ctrl;
  logic clk = 0, rst = 1, sound_en = 0, div_tick = 0, cs = 0, wr = 0, rd = 0;
  logic [7:0] a = 0, din = 0;
  logic [7:0] dout, dout2;
  logic [2:0] sweep_time, num_sweep_shifts, num_envelope_sweeps;
  logic sweep_decreasing, envelope_increasing, single, start, clk_length_ctr, clk_sweep, clk_vol_env, dac_on;
  logic [1:0] wave_duty;
  logic [5:0] length;
  logic [3:0] initial_volume;
  logic [10:0] frequency;
  logic [2:0] sweep_time2, num_sweep_shifts2, num_envelope_sweeps2;
  logic sweep_decreasing2, envelope_increasing2, single2, start2, clk_length_ctr2, clk_sweep2, clk_vol_env2, dac_on2;
  logic [1:0] wave_duty2;
  logic [5:0] length2;
  logic [3:0] initial_volume2;
  logic [10:0] frequency2;
  int checks = 0, errors = 0;
  int n_len, n_sw, n_vol;
  logic p_len, p_sw, p_vol;
  always #5 clk = ~clk;
  sound_square_ctrl #(.BASE_ADDR(8'h10), .HAS_SWEEP(1'b1)) dut (
    .clk(clk), .rst(rst), .sound_en(sound_en), .div_tick(div_tick), .cs(cs), .a(a), .din(din),
    .wr(wr), .rd(rd), .dout(dout), .sweep_time(sweep_time), .sweep_decreasing(sweep_decreasing),
    .num_sweep_shifts(num_sweep_shifts), .wave_duty(wave_duty), .length(length),
    .initial_volume(initial_volume), .envelope_increasing(envelope_increasing),
    .num_envelope_sweeps(num_envelope_sweeps), .frequency(frequency), .single(single), .start(start),
    .clk_length_ctr(clk_length_ctr), .clk_sweep(clk_sweep), .clk_vol_env(clk_vol_env), .dac_on(dac_on));
  sound_square_ctrl #(.BASE_ADDR(8'h15), .HAS_SWEEP(1'b0)) dut2 (
    .clk(clk), .rst(rst), .sound_en(sound_en), .div_tick(div_tick), .cs(cs), .a(a), .din(din),
    .wr(wr), .rd(rd), .dout(dout2), .sweep_time(sweep_time2), .sweep_decreasing(sweep_decreasing2),
    .num_sweep_shifts(num_sweep_shifts2), .wave_duty(wave_duty2), .length(length2),
    .initial_volume(initial_volume2), .envelope_increasing(envelope_increasing2),
    .num_envelope_sweeps(num_envelope_sweeps2), .frequency(frequency2), .single(single2), .start(start2),
    .clk_length_ctr(clk_length_ctr2), .clk_sweep(clk_sweep2), .clk_vol_env(clk_vol_env2), .dac_on(dac_on2));
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr_reg(input logic [7:0] ad, input logic [7:0] d);
    @(negedge clk); cs = 1; wr = 1; a = ad; din = d;
    @(negedge clk); cs = 0; wr = 0;
  endtask
  task automatic rd_reg(input logic [7:0] ad);
    @(negedge clk); cs = 1; rd = 1; a = ad;
    @(negedge clk); cs = 0; rd = 0;
  endtask
  task automatic tick;
    @(negedge clk); div_tick = 1;
    @(negedge clk); div_tick = 0;
  endtask
  initial begin
    sound_en = 1;
    #12;
    chk("rst_dout", dout, 8'hFF);
    chk("rst_start", start, 0);
    chk("rst_freq", frequency, 0);
    chk("rst_clocks", {clk_length_ctr, clk_sweep, clk_vol_env}, 0);
    chk("rst_dac", dac_on, 0);
    @(negedge clk); rst = 0;
    wr_reg(8'h12, 8'hF3);
    chk("nr2_vol", initial_volume, 4'hF);
    chk("nr2_sweeps", num_envelope_sweeps, 3);
    chk("nr2_inc", envelope_increasing, 0);
    chk("nr2_dac", dac_on, 1);
    wr_reg(8'h13, 8'h34);
    chk("pre_trig_start", start, 0);
    wr_reg(8'h14, 8'hC5);
    chk("trig_start", start, 1);
    chk("trig_freq", frequency, 11'h534);
    chk("trig_single", single, 1);
    @(negedge clk);
    chk("trig_one_clk", start, 0);
    wr_reg(8'h12, 8'h00);
    chk("dac_off", dac_on, 0);
    wr_reg(8'h14, 8'h80);
    chk("trig_dac_off", start, 0);
    wr_reg(8'h12, 8'h08);
    chk("dac_on_08", dac_on, 1);
    wr_reg(8'h14, 8'h80);
    chk("trig_08", start, 1);
    chk("single_cleared", single, 0);
    @(negedge clk);
    chk("trig_08_end", start, 0);
    cs = 1; wr = 1; a = 8'h14; din = 8'h80;
    @(negedge clk);
    chk("b2b_first", start, 1);
    @(negedge clk); cs = 0; wr = 0;
    chk("b2b_second", start, 1);
    @(negedge clk);
    chk("b2b_end", start, 0);
    n_len = 0; n_sw = 0; n_vol = 0;
    p_len = clk_length_ctr; p_sw = clk_sweep; p_vol = clk_vol_env;
    chk("seq_idle", {p_len, p_sw, p_vol}, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_len += int'(clk_length_ctr && !p_len);
      n_sw  += int'(clk_sweep && !p_sw);
      n_vol += int'(clk_vol_env && !p_vol);
      if (i == 6) chk("vol_before_7", clk_vol_env, 0);
      if (i == 7) chk("vol_at_7", clk_vol_env, 1);
      p_len = clk_length_ctr; p_sw = clk_sweep; p_vol = clk_vol_env;
    end
    chk("len_rises", n_len, 8);
    chk("sweep_rises", n_sw, 4);
    chk("vol_rises", n_vol, 2);
    wr_reg(8'h10, 8'h5B);
    chk("ch1_sweep", {sweep_time, sweep_decreasing, num_sweep_shifts}, {3'd5, 1'b1, 3'd3});
    wr_reg(8'h15, 8'hFF);
    chk("ch2_sweep_tied", {sweep_time2, sweep_decreasing2, num_sweep_shifts2}, 0);
    wr_reg(8'h16, 8'hC0);
    chk("ch2_duty", wave_duty2, 2'd3);
    wr_reg(8'h11, 8'h81);
    chk("nr1_duty", wave_duty, 2'd2);
    chk("nr1_len", length, 6'd1);
    chk("ch2_len_untouched", {wave_duty2, length2}, 8'hC0);
    rd_reg(8'h11);
`ifdef SQ_CTRL_READBACK_EN
    chk("rd_nr1", dout, 8'hBF);
`else
    chk("rd_nr1", dout, 8'hFF);
`endif
    @(negedge clk);
    chk("rd_idle", dout, 8'hFF);
    rd_reg(8'h10);
`ifdef SQ_CTRL_READBACK_EN
    chk("rd_nr0", dout, 8'hDB);
`else
    chk("rd_nr0", dout, 8'hFF);
`endif
    rd_reg(8'h13);
    chk("rd_nr3", dout, 8'hFF);
    rd_reg(8'h15);
    chk("rd_oor", dout, 8'hFF);
    chk("rd_ch2_nr0", dout2, 8'hFF);
    rd_reg(8'h14);
`ifdef SQ_CTRL_READBACK_EN
    chk("rd_nr4", dout, 8'hBF);
`else
    chk("rd_nr4", dout, 8'hFF);
`endif
    @(negedge clk); cs = 1; rd = 1; wr = 1; a = 8'h12; din = 8'hF0;
    @(negedge clk); cs = 0; rd = 0; wr = 0;
`ifdef SQ_CTRL_READBACK_EN
    chk("rd_wr_same", dout, 8'h08);
`else
    chk("rd_wr_same", dout, 8'hFF);
`endif
    chk("rd_wr_written", initial_volume, 4'hF);
    tick(); tick(); tick();
    chk("mid_seq", {clk_length_ctr, clk_sweep}, 2'b01);
    @(negedge clk); sound_en = 0; cs = 1; wr = 1; a = 8'h13; din = 8'hAA;
    @(negedge clk); cs = 0; wr = 0;
    chk("off_fields", {initial_volume, wave_duty, length}, 0);
    chk("off_freq", frequency, 0);
    chk("off_clocks", {clk_length_ctr, clk_sweep, clk_vol_env}, 0);
    chk("off_dac", dac_on, 0);
    sound_en = 1;
    @(negedge clk);
    chk("on_freq", frequency, 0);
    tick(); tick();
    chk("restart_step2", {clk_length_ctr, clk_sweep, clk_vol_env}, 3'b110);
    wr_reg(8'h12, 8'hF0);
    @(negedge clk); cs = 1; wr = 1; a = 8'h14; din = 8'h80;
    @(negedge clk); cs = 0; wr = 0;
    chk("pre_rst_start", start, 1);
    #2 rst = 1;
    #1;
    chk("async_start", start, 0);
    chk("async_fields", {initial_volume, dac_on, clk_length_ctr, clk_sweep}, 0);
    @(negedge clk); rst = 0;
    wr_reg(8'h12, 8'hF0);
    wr_reg(8'h14, 8'h87);
    chk("post_rst_start", start, 1);
    chk("post_rst_freq", frequency, 11'h700);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sound_square_ctrl.md
Name: sound_square_ctrl

Overview:
- CPU-side register front end and frame sequencer for one square channel; drives every control input of the square channel generator.
- Holds NRx0–NRx4 and decodes them into the channel's parameter fields.
- Produces the trigger (start) pulse and the length, sweep and envelope timing clocks.
- Instantiate once for channel 1 (BASE_ADDR=8'h10, HAS_SWEEP=1) and once for channel 2 (BASE_ADDR=8'h15, HAS_SWEEP=0).

Parameters:
- BASE_ADDR, 8'h10, low address byte of NRx0; registers occupy BASE_ADDR+0..+4.
- HAS_SWEEP, 1, 1 = NRx0 implemented; 0 = NRx0 absent, reads 8'hFF, writes ignored, sweep outputs tied 0.

Ports:
- clk  in  1  CPU clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- sound_en  in  1  NR52 bit7 master enable; low clears registers and holds the sequencer.
- div_tick  in  1  one-clk pulse at 512 Hz from the timer divider.
- cs  in  1  sound register region select.
- a  in  8  low address byte.
- din  in  8  write data.
- wr  in  1  write strobe, one clk.
- rd  in  1  read strobe, one clk.
- dout  out  8  read data.
- sweep_time  out  3  NRx0[6:4].
- sweep_decreasing  out  1  NRx0[3].
- num_sweep_shifts  out  3  NRx0[2:0].
- wave_duty  out  2  NRx1[7:6].
- length  out  6  NRx1[5:0].
- initial_volume  out  4  NRx2[7:4].
- envelope_increasing  out  1  NRx2[3].
- num_envelope_sweeps  out  3  NRx2[2:0].
- frequency  out  11  {NRx4[2:0], NRx3}.
- single  out  1  NRx4[6].
- start  out  1  trigger pulse.
- clk_length_ctr  out  1  256 Hz length clock.
- clk_sweep  out  1  128 Hz sweep clock.
- clk_vol_env  out  1  64 Hz envelope clock.
- dac_on  out  1  NRx2[7:3] != 0.

Behaviour:
- Reset: all register fields 0, dout=8'hFF, start=0, step=0, all three timing clocks 0, dac_on=0.
- Write:
  - Occurs on the clk edge where cs&wr&sound_en and a is in BASE_ADDR..BASE_ADDR+4; the field is updated at that edge.
  - Out-of-range addresses are ignored.
  - Writes while sound_en=0 are ignored.
- Trigger:
  - A write to NRx4 with din[7]=1 and DAC on sets start=1 for exactly one clk, on the cycle after the write edge.
  - DAC on is judged on the NRx2 value in effect at that edge.
  - All fields, including that same write's NRx4 bits, are already stable when start rises.
  - NRx4 bit7 is not stored.
  - Trigger with DAC off: no start pulse.
  - Back-to-back trigger writes on consecutive clks give start high for 2 consecutive clks.
- Read:
  - On cs&rd with an in-range address, dout is registered the next clk with the masked value: NRx0|8'h80, NRx1|8'h3F, NRx2, NRx3→8'hFF, NRx4|8'hBF.
  - Out-of-range address or no read: dout=8'hFF.
  - A read in the same cycle as a write to the same register returns the pre-write value.
- sound_en low:
  - Registers cleared synchronously each clk.
  - step held at 0; timing clocks 0; start suppressed.
  - Reads still return the masked, cleared values.
- Frame sequencer:
  - 3-bit step increments mod 8 on each div_tick while sound_en=1; wraps 7→0.
  - Timing clocks are registered decodes of step:
    - clk_length_ctr = ~step[0] (rises on entry to steps 0,2,4,6).
    - clk_sweep = step[1] (rises on entry to steps 2,6).
    - clk_vol_env = (step==7).
  - A rising sound_en restarts from step 0 with all clocks low.
  - div_tick coinciding with a trigger write: both take effect in the same clk.
- Sweep fields: when HAS_SWEEP=0, sweep outputs are constant 0.

Optional Feature:
- SQ_CTRL_READBACK_EN defined: read path as above.
- Undefined: no read mux or dout register; dout constant 8'hFF; rd ignored. All write, trigger and sequencer behaviour is unchanged.

Test Plan:
- Reset, then write NRx2=8'hF3, NRx3=8'h34, NRx4=8'hC5 → start pulses 1 clk after the NRx4 write; frequency=11'h534, single=1, initial_volume=15, num_envelope_sweeps=3.
- NRx2=8'h00, then NRx4=8'h80 → no start, dac_on=0. Then NRx2=8'h08, NRx4=8'h80 → start pulses once.
- 16 div_tick pulses → clk_length_ctr 8 rising edges, clk_sweep 4, clk_vol_env 2. The first clk_vol_env rise follows the 7th tick.
- Write NRx1=8'h81, read NRx1 → 8'hBF; read NRx3 → 8'hFF; read BASE_ADDR+5 → 8'hFF. With HAS_SWEEP=0, read NRx0 → 8'hFF.
- Mid-sequence, drop sound_en for 1 clk → fields 0, step 0, clocks low. A write during sound_en=0 has no effect.
- Assert rst during a start pulse → start and all outputs clear immediately (async); normal operation after release.
